// File: rtl/pb_varint_stream_decoder_if.sv
// Byte-in / decoded-varint-out handshake bundle for pb_varint_stream_decoder.
interface pb_varint_stream_decoder_if #(
    parameter int VALUE_W = 64,
    parameter int CNT_W   = $clog2((VALUE_W / 7) + 2)
);
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_byte;
    logic               in_last;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [VALUE_W-1:0] out_value;
    logic [2:0]         out_wire_type;
    logic [CNT_W-1:0]   out_len;
    logic [2:0]         out_err;

    modport master (
        output in_valid, in_byte, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_value, out_wire_type, out_len, out_err
    );

    modport slave (
        input  in_valid, in_byte, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_value, out_wire_type, out_len, out_err
    );
endinterface

// File: rtl/pb_varint_stream_decoder.sv
// Streaming protobuf varint decoder (raw / zigzag / key), one byte per cycle.
// Latency: result valid the cycle after the terminating byte; one bubble per varint.
// Backpressure: in_ready drops while a result waits; out_* hold until out_ready.
module pb_varint_stream_decoder #(
    parameter int VALUE_W   = 64,
    parameter int MAX_BYTES = (VALUE_W / 7) + 1,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pb_varint_stream_decoder_if.slave bus
);
    localparam int WIDE_W = 7 * MAX_BYTES;
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(MAX_BYTES - 1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_BYTES);
    localparam logic [2:0] ERR_OK = 3'd0, ERR_OVERLONG = 3'd1, ERR_TRUNC = 3'd2,
                           ERR_OVF = 3'd3, ERR_BAD_WT = 3'd4;

    typedef enum logic [1:0] {ACCUM = 2'd0, OUT = 2'd1, DRAIN = 2'd2} state_t;

    state_t             state;
    logic [VALUE_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic [1:0]         mode;
    logic               drain_pend;
    logic [VALUE_W-1:0] value_q;
    logic [2:0]         wire_type_q;
    logic [CNT_W-1:0]   len_q;
    logic [2:0]         err_q;

    logic [CNT_W+2:0]   shamt;
    logic [WIDE_W-1:0]  wide;
    logic [VALUE_W-1:0] raw_nxt;
    logic [VALUE_W-1:0] val_nxt;
    logic [2:0]         wt_nxt;
    logic [2:0]         err_nxt;
    logic [CNT_W-1:0]   len_nxt;
    logic [1:0]         mode_nxt;
    logic               ovf_nxt;
    logic               cont;
    logic               overlong;
    logic               trunc;
    logic               term;
    logic               bad_wt;

    always_comb begin
        // Payload is placed in a field wide enough to expose bits that fall off the top.
        shamt    = {cnt, 3'b000} - {3'b000, cnt};
        wide     = {{(WIDE_W-7){1'b0}}, bus.in_byte[6:0]} << shamt;
        raw_nxt  = acc | wide[VALUE_W-1:0];
        ovf_nxt  = ovf | (|wide[WIDE_W-1:VALUE_W]);
        mode_nxt = (cnt == '0) ? bus.in_mode : mode;
        cont     = bus.in_byte[7];
        overlong = cont && (cnt == LAST_K);
        trunc    = cont && bus.in_last;
        term     = !cont || overlong || trunc;
        len_nxt  = (cnt >= LAST_K) ? LEN_MAX : cnt + CNT_W'(1);
        val_nxt  = raw_nxt;
        wt_nxt   = 3'd0;
        case (mode_nxt)
            2'd1: val_nxt = {VALUE_W{raw_nxt[0]}} ^ (raw_nxt >> 1);
            2'd2: begin
                val_nxt = raw_nxt >> 3;
                wt_nxt  = raw_nxt[2:0];
            end
            default: ;
        endcase
        bad_wt = (mode_nxt == 2'd2) &&
                 (wt_nxt == 3'd3 || wt_nxt == 3'd4 || wt_nxt == 3'd6 || wt_nxt == 3'd7);
        if (overlong)     err_nxt = ERR_OVERLONG;
        else if (trunc)   err_nxt = ERR_TRUNC;
        else if (ovf_nxt) err_nxt = ERR_OVF;
        else if (bad_wt)  err_nxt = ERR_BAD_WT;
        else              err_nxt = ERR_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            mode        <= 2'd0;
            drain_pend  <= 1'b0;
            value_q     <= '0;
            wire_type_q <= 3'd0;
            len_q       <= '0;
            err_q       <= ERR_OK;
        end else begin
            case (state)
                ACCUM: if (bus.in_valid) begin
                    mode <= mode_nxt;
                    if (term) begin
                        state       <= OUT;
                        value_q     <= val_nxt;
                        wire_type_q <= wt_nxt;
                        len_q       <= len_nxt;
                        err_q       <= err_nxt;
                        drain_pend  <= overlong && !bus.in_last;
                    end else begin
                        acc <= raw_nxt;
                        ovf <= ovf_nxt;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUT: if (bus.out_ready) begin
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    state <= drain_pend ? DRAIN : ACCUM;
                end
                DRAIN: if (bus.in_valid && (!bus.in_byte[7] || bus.in_last)) begin
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready      = (state != OUT);
    assign bus.out_valid     = (state == OUT);
    assign bus.out_value     = value_q;
    assign bus.out_wire_type = wire_type_q;
    assign bus.out_len       = len_q;
    assign bus.out_err       = err_q;
endmodule

// File: tb/tb_pb_varint_stream_decoder.sv
// Scoreboarded bench for pb_varint_stream_decoder: directed vectors, backpressure, reset, random traffic.
module tb_pb_varint_stream_decoder;
    localparam int VALUE_W = 64;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic [63:0] v;
        logic [2:0]  wt;
        logic [3:0]  len;
        logic [2:0]  err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic hold;
    logic rnd_rdy;
    logic gaps;
    exp_t sb[$];
    logic [8:0] vbytes[$];

    pb_varint_stream_decoder_if #(.VALUE_W(VALUE_W), .CNT_W(CNT_W)) bus ();

    pb_varint_stream_decoder #(.VALUE_W(VALUE_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode of vbytes, written straight from the varint rules.
    function automatic exp_t model(input logic [1:0] m);
        logic [127:0] a;
        logic [63:0]  raw;
        int           k;
        logic         c;
        logic         l;
        exp_t         r;
        a = '0;
        k = 0;
        for (int i = 0; i < vbytes.size(); i++) begin
            k = i;
            a = a | ({121'd0, vbytes[i][6:0]} << (7 * i));
            if (!vbytes[i][7] || vbytes[i][8] || i == 9) break;
        end
        c = vbytes[k][7];
        l = vbytes[k][8];
        raw = a[63:0];
        r.len = 4'(k + 1);
        r.wt = 3'd0;
        r.v = raw;
        if (m == 2'd1) r.v = (raw >> 1) ^ (-(raw & 64'd1));
        else if (m == 2'd2) begin
            r.v = raw >> 3;
            r.wt = raw[2:0];
        end
        if (c && k == 9) r.err = 3'd1;
        else if (c && l) r.err = 3'd2;
        else if (a[127:64] != 0) r.err = 3'd3;
        else if (m == 2'd2 && r.wt inside {3'd3, 3'd4, 3'd6, 3'd7}) r.err = 3'd4;
        else r.err = 3'd0;
        return r;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input logic l, input logic [1:0] m);
        int   t;
        logic took;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = l;
        bus.in_mode  = m;
        t = 0;
        do begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!took && t < 1000);
        if (!took) chk("in_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'($urandom_range(0, 3));
    endtask

    task automatic send(input logic [1:0] m);
        for (int i = 0; i < vbytes.size(); i++)
            drive_byte(vbytes[i][7:0], vbytes[i][8], (i == 0) ? m : 2'($urandom_range(0, 3)));
    endtask

    task automatic send_exp(input logic [1:0] m, input logic [63:0] v, input logic [2:0] wt,
                            input logic [3:0] len, input logic [2:0] err);
        exp_t e;
        e.v = v; e.wt = wt; e.len = len; e.err = err;
        sb.push_back(e);
        send(m);
    endtask

    task automatic vb(input logic [8:0] b);
        vbytes.push_back(b);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        out_ready_loop();
    end

    task automatic out_ready_loop();
        forever begin
            @(posedge clk);
            #2;
            if (hold) bus.out_ready = 1'b0;
            else if (rnd_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
            else bus.out_ready = 1'b1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("out_value", bus.out_value, e.v);
                    chk("out_wire_type", 64'(bus.out_wire_type), 64'(e.wt));
                    chk("out_len", 64'(bus.out_len), 64'(e.len));
                    chk("out_err", 64'(bus.out_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        int   t;
        int   kind;
        int   len;
        logic [1:0] m;
        logic lst;
        tests_run = 0; tests_failed = 0;
        hold = 1'b0; rnd_rdy = 1'b0; gaps = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0; bus.in_mode = 2'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_value", bus.out_value, 64'd0);
        chk("rst_out_len", 64'(bus.out_len), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        vbytes.delete(); vb(9'h096); vb(9'h001); send_exp(2'd0, 64'd150, 3'd0, 4'd2, 3'd0);
        vbytes.delete(); vb(9'h000); send_exp(2'd0, 64'd0, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); vb(9'h003); send_exp(2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); vb(9'h004); send_exp(2'd1, 64'd2, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); repeat (9) vb(9'h0FF); vb(9'h001);
        send_exp(2'd1, 64'h8000_0000_0000_0000, 3'd0, 4'd10, 3'd0);
        vbytes.delete(); vb(9'h008); send_exp(2'd2, 64'd1, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); vb(9'h092); vb(9'h001); send_exp(2'd2, 64'd18, 3'd2, 4'd2, 3'd0);
        vbytes.delete(); vb(9'h00B); send_exp(2'd2, 64'd1, 3'd3, 4'd1, 3'd4);
        vbytes.delete(); repeat (11) vb(9'h080); vb(9'h000);
        send_exp(2'd0, 64'd0, 3'd0, 4'd10, 3'd1);
        vbytes.delete(); vb(9'h005); send_exp(2'd0, 64'd5, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); vb(9'h180); send_exp(2'd0, 64'd0, 3'd0, 4'd1, 3'd2);
        vbytes.delete(); repeat (9) vb(9'h0FF); vb(9'h002);
        send_exp(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 3'd0, 4'd10, 3'd3);
        vbytes.delete(); vb(9'h105); send_exp(2'd0, 64'd5, 3'd0, 4'd1, 3'd0);
        vbytes.delete(); vb(9'h096); vb(9'h001); send_exp(2'd3, 64'd150, 3'd0, 4'd2, 3'd0);
        wait_idle();

        // Backpressure: result must sit still and block input.
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vbytes.delete(); vb(9'h096); vb(9'h001); send_exp(2'd0, 64'd150, 3'd0, 4'd2, 3'd0);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) chk("bp_timeout", 64'd0, 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_value", bus.out_value, 64'd150);
            chk("bp_out_len", 64'(bus.out_len), 64'd2);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        wait_idle();

        // Reset mid-varint discards the partial value.
        drive_byte(8'h96, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vbytes.delete(); vb(9'h001); send_exp(2'd0, 64'd1, 3'd0, 4'd1, 3'd0);
        wait_idle();

        gaps = 1'b1;
        rnd_rdy = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            vbytes.delete();
            m = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                repeat (10) vb({1'b0, 1'b1, 7'($urandom)});
                repeat ($urandom_range(0, 3)) vb({1'b0, 1'b1, 7'($urandom)});
                lst = 1'($urandom_range(0, 1));
                vb({lst, lst ? 1'($urandom_range(0, 1)) : 1'b0, 7'($urandom)});
            end else if (kind == 1) begin
                len = $urandom_range(1, 9);
                for (int i = 0; i < len; i++) vb({(i == len - 1), 1'b1, 7'($urandom)});
            end else begin
                len = $urandom_range(1, 10);
                for (int i = 0; i < len - 1; i++) vb({1'b0, 1'b1, 7'($urandom)});
                vb({1'($urandom_range(0, 1)), 1'b0, 7'($urandom)});
            end
            sb.push_back(model(m));
            send(m);
        end
        wait_idle();
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
